alu_op_sequencer: RTL and testbench

//  Sequences the 8-bit ALU for the CPU core: accepts one op request via valid/ready, drives the ALU enables/operands, and chains two byte passes for 16-bit ops.

---
 rtl/alu_op_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences an external 8-bit combinational ALU through one or two byte passes per request.
// Optional decimal mode for ADC/SBC is enabled by defining ALU_SEQ_BCD_EN (adds the req_d input).
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_w16,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_c,
  input  logic        req_v,
`ifdef ALU_SEQ_BCD_EN
  input  logic        req_d,
`endif
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_n,
  output logic        res_z,
  output logic        res_c,
  output logic        res_v,
  output logic        alu_sum_en,
  output logic        alu_and_en,
  output logic        alu_eor_en,
  output logic        alu_or_en,
  output logic        alu_sr_en,
  output logic        alu_ror_en,
  output logic        alu_inv_en,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_res,
  input  logic        alu_cout,
  input  logic        alu_ovf
);

  localparam logic [2:0] OP_ADC = 3'd0;
  localparam logic [2:0] OP_SBC = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_EOR = 3'd3;
  localparam logic [2:0] OP_ORA = 3'd4;
  localparam logic [2:0] OP_LSR = 3'd5;
  localparam logic [2:0] OP_ROR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_P1   = 2'd1,
    ST_P2   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic en_sum;
    logic en_and;
    logic en_eor;
    logic en_ora;
    logic en_sr;
    logic en_ror;
    logic en_inv;
  } alu_ctl_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_LSR) || (op == OP_ROR);
  endfunction

  function automatic logic is_addsub(input logic [2:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

  // Ops whose C flag and inter-pass carry come from the ALU carry output.
  function automatic logic is_chain(input logic [2:0] op);
    return is_addsub(op) || (op == OP_CMP) || is_shift(op);
  endfunction

  function automatic logic [7:0] pick_byte(input logic [15:0] x, input logic hi);
    return hi ? x[15:8] : x[7:0];
  endfunction

  function automatic logic first_cin(input logic [2:0] op, input logic c);
    logic cin;
    case (op)
      OP_ADC, OP_SBC, OP_ROR: cin = c;
      OP_CMP:                 cin = 1'b1;
      default:                cin = 1'b0;
    endcase
    return cin;
  endfunction

  function automatic alu_ctl_t pass_ctl(input logic [2:0] op, input logic first);
    alu_ctl_t ctl;
    ctl = '0;
    case (op)
      OP_ADC: ctl.en_sum = 1'b1;
      OP_SBC, OP_CMP: begin
        ctl.en_sum = 1'b1;
        ctl.en_inv = 1'b1;
      end
      OP_AND: ctl.en_and = 1'b1;
      OP_EOR: ctl.en_eor = 1'b1;
      OP_ORA: ctl.en_ora = 1'b1;
      OP_LSR: begin
        if (first) ctl.en_sr = 1'b1;
        else       ctl.en_ror = 1'b1;
      end
      OP_ROR: ctl.en_ror = 1'b1;
      default: ctl = '0;
    endcase
    return ctl;
  endfunction

  state_t      state_q;
  logic [2:0]  op_q;
  logic        w16_q;
  logic [7:0]  a_p2_q;
  logic [7:0]  b_p2_q;
  logic        c_q;
  logic        v_q;
  logic        ready_q;
  logic        res_valid_q;
  logic [15:0] res_data_q;
  logic        res_n_q;
  logic        res_z_q;
  logic        res_c_q;
  logic        res_v_q;
  alu_ctl_t    ctl_q;
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic        alu_cin_q;
  logic [7:0]  byte1_q;
  logic [7:0]  byte1_bin_q;
`ifdef ALU_SEQ_BCD_EN
  logic        d_q;
  logic [4:0]  half_sum_d;
  logic [4:0]  half_dif_d;
  logic [8:0]  dec_lo_d;
  logic [7:0]  dec_sub_d;
`endif

  logic [7:0]  cap_byte_d;
  logic        cap_carry_d;
  logic [15:0] fin_data_d;
  logic [15:0] fin_bin_d;
  logic        fin_n_d;
  logic        fin_z_d;
  logic        fin_c_d;
  logic        fin_v_d;

  // Byte captured at the end of a pass, decimal-adjusted when requested.
  always_comb begin
    cap_byte_d  = alu_res;
    cap_carry_d = alu_cout;
`ifdef ALU_SEQ_BCD_EN
    half_sum_d = {1'b0, alu_a_q[3:0]} + {1'b0, alu_b_q[3:0]} + {4'd0, alu_cin_q};
    half_dif_d = {1'b0, alu_a_q[3:0]} + {1'b0, ~alu_b_q[3:0]} + {4'd0, alu_cin_q};
    if (half_sum_d[4] || (alu_res[3:0] > 4'd9)) begin
      dec_lo_d = {1'b0, alu_res} + 9'h006;
    end else begin
      dec_lo_d = {1'b0, alu_res};
    end
    if (half_dif_d[4]) begin
      dec_sub_d = alu_res;
    end else begin
      dec_sub_d = alu_res - 8'h06;
    end
    if (d_q && (op_q == OP_ADC)) begin
      if (alu_cout || (dec_lo_d > 9'h09F)) begin
        cap_byte_d  = dec_lo_d[7:0] + 8'h60;
        cap_carry_d = 1'b1;
      end else begin
        cap_byte_d  = dec_lo_d[7:0];
        cap_carry_d = 1'b0;
      end
    end else if (d_q && (op_q == OP_SBC)) begin
      if (alu_cout) begin
        cap_byte_d = dec_sub_d;
      end else begin
        cap_byte_d = dec_sub_d - 8'h60;
      end
      cap_carry_d = alu_cout;
    end else begin
      cap_byte_d  = alu_res;
      cap_carry_d = alu_cout;
    end
`endif
  end

  // Final result and flags; N/Z/V always come from the binary bytes.
  always_comb begin
    if (state_q == ST_P2) begin
      if (is_shift(op_q)) begin
        fin_data_d = {byte1_q, cap_byte_d};
        fin_bin_d  = {byte1_bin_q, alu_res};
      end else begin
        fin_data_d = {cap_byte_d, byte1_q};
        fin_bin_d  = {alu_res, byte1_bin_q};
      end
      fin_n_d = fin_bin_d[15];
    end else begin
      fin_data_d = {8'h00, cap_byte_d};
      fin_bin_d  = {8'h00, alu_res};
      fin_n_d    = alu_res[7];
    end
    fin_z_d = (fin_bin_d == 16'h0000);
    if (is_chain(op_q)) begin
      fin_c_d = cap_carry_d;
    end else begin
      fin_c_d = c_q;
    end
    if (is_addsub(op_q)) begin
      fin_v_d = alu_ovf;
    end else begin
      fin_v_d = v_q;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      w16_q       <= 1'b0;
      a_p2_q      <= 8'h00;
      b_p2_q      <= 8'h00;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'h0000;
      res_n_q     <= 1'b0;
      res_z_q     <= 1'b0;
      res_c_q     <= 1'b0;
      res_v_q     <= 1'b0;
      ctl_q       <= '0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_cin_q   <= 1'b0;
      byte1_q     <= 8'h00;
      byte1_bin_q <= 8'h00;
`ifdef ALU_SEQ_BCD_EN
      d_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && ready_q) begin
            state_q   <= ST_P1;
            ready_q   <= 1'b0;
            op_q      <= req_op;
            w16_q     <= req_w16;
            a_p2_q    <= pick_byte(req_a, !is_shift(req_op));
            b_p2_q    <= req_b[15:8];
            c_q       <= req_c;
            v_q       <= req_v;
`ifdef ALU_SEQ_BCD_EN
            d_q       <= req_d;
`endif
            // Shifts walk the word from the high byte down.
            ctl_q     <= pass_ctl(req_op, 1'b1);
            alu_a_q   <= pick_byte(req_a, req_w16 && is_shift(req_op));
            alu_b_q   <= is_shift(req_op) ? 8'h00 : req_b[7:0];
            alu_cin_q <= first_cin(req_op, req_c);
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_P1, ST_P2: begin
          if ((state_q == ST_P1) && w16_q) begin
            state_q     <= ST_P2;
            byte1_q     <= cap_byte_d;
            byte1_bin_q <= alu_res;
            ctl_q       <= pass_ctl(op_q, 1'b0);
            alu_a_q     <= a_p2_q;
            alu_b_q     <= is_shift(op_q) ? 8'h00 : b_p2_q;
            alu_cin_q   <= is_chain(op_q) ? cap_carry_d : 1'b0;
          end else begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
            res_data_q  <= fin_data_d;
            res_n_q     <= fin_n_d;
            res_z_q     <= fin_z_d;
            res_c_q     <= fin_c_d;
            res_v_q     <= fin_v_d;
            ctl_q       <= '0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_cin_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_n      = res_n_q;
  assign res_z      = res_z_q;
  assign res_c      = res_c_q;
  assign res_v      = res_v_q;
  assign alu_sum_en = ctl_q.en_sum;
  assign alu_and_en = ctl_q.en_and;
  assign alu_eor_en = ctl_q.en_eor;
  assign alu_or_en  = ctl_q.en_ora;
  assign alu_sr_en  = ctl_q.en_sr;
  assign alu_ror_en = ctl_q.en_ror;
  assign alu_inv_en = ctl_q.en_inv;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural 8-bit ALU plus a whole-word reference model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_w16;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_c;
  logic        req_v;
`ifdef ALU_SEQ_BCD_EN
  logic        req_d;
`endif
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_n, res_z, res_c, res_v;
  logic        alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_ror_en, alu_inv_en;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic        alu_cin, alu_cout, alu_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] o_data;
  logic [3:0]  o_nzcv;
  int          o_lat, o_wait, o_busy_ready, o_bad_en, o_unstable, o_hold_ready;
  logic        o_timeout;

  logic [7:0]  m_bb;
  logic [8:0]  m_s;

  typedef struct packed {
    logic [2:0]  op;
    logic        w16;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        v;
    logic [15:0] exp_data;
    logic [3:0]  exp_nzcv;
    logic [1:0]  exp_lat;
  } vec_t;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_w16(req_w16),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_v(req_v),
`ifdef ALU_SEQ_BCD_EN
    .req_d(req_d),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_n(res_n), .res_z(res_z), .res_c(res_c), .res_v(res_v),
    .alu_sum_en(alu_sum_en), .alu_and_en(alu_and_en), .alu_eor_en(alu_eor_en),
    .alu_or_en(alu_or_en), .alu_sr_en(alu_sr_en), .alu_ror_en(alu_ror_en), .alu_inv_en(alu_inv_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational 8-bit ALU sitting outside the sequencer.
  always_comb begin
    m_bb     = alu_inv_en ? ~alu_b : alu_b;
    m_s      = {1'b0, alu_a} + {1'b0, m_bb} + {8'd0, alu_cin};
    alu_res  = 8'h00;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_sum_en) begin
      alu_res  = m_s[7:0];
      alu_cout = m_s[8];
      alu_ovf  = (alu_a[7] == m_bb[7]) && (m_s[7] != alu_a[7]);
    end else if (alu_and_en) begin
      alu_res = alu_a & alu_b;
    end else if (alu_eor_en) begin
      alu_res = alu_a ^ alu_b;
    end else if (alu_or_en) begin
      alu_res = alu_a | alu_b;
    end else if (alu_sr_en) begin
      alu_res  = {1'b0, alu_a[7:1]};
      alu_cout = alu_a[0];
    end else if (alu_ror_en) begin
      alu_res  = {alu_cin, alu_a[7:1]};
      alu_cout = alu_a[0];
    end else begin
      alu_res = 8'h00;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int en_count();
    return $countones({alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_ror_en, alu_inv_en});
  endfunction

  // Whole-word arithmetic on the selected width.
  function automatic void ref_model(input logic [2:0] op, input logic w16, input logic [15:0] a,
                                    input logic [15:0] b, input logic c, input logic v,
                                    output logic [15:0] r, output logic [3:0] nzcv);
    int unsigned msk, top, aa, bb, full, rr;
    logic co, vo;
    msk  = w16 ? 32'h0000_FFFF : 32'h0000_00FF;
    top  = w16 ? 32'h0000_8000 : 32'h0000_0080;
    aa   = 32'(a) & msk;
    bb   = 32'(b) & msk;
    co   = c;
    vo   = v;
    full = 32'd0;
    rr   = 32'd0;
    case (op)
      3'd0, 3'd1, 3'd7: begin
        if (op != 3'd0) bb = bb ^ msk;
        full = aa + bb + ((op == 3'd7) ? 32'd1 : 32'(c));
        rr   = full & msk;
        co   = (full > msk);
        if (op != 3'd7) vo = (((aa ^ rr) & (bb ^ rr) & top) != 32'd0);
      end
      3'd2: rr = aa & bb;
      3'd3: rr = aa ^ bb;
      3'd4: rr = aa | bb;
      3'd5: begin
        rr = aa >> 1;
        co = aa[0];
      end
      3'd6: begin
        rr = (aa >> 1) | (c ? top : 32'd0);
        co = aa[0];
      end
      default: rr = 32'd0;
    endcase
    r    = rr[15:0];
    nzcv = {((rr & top) != 32'd0), (rr == 32'd0), co, vo};
  endfunction

  // Drives one request and records what the DUT did; hold = cycles res_ready stays low.
  task automatic run_op(input logic [2:0] op, input logic w16, input logic [15:0] a,
                        input logic [15:0] b, input logic c, input logic v, input int hold);
    int k;
    int exp_en;
    exp_en = ((op == 3'd1) || (op == 3'd7)) ? 2 : 1;
    o_timeout = 1'b0; o_wait = 0; o_busy_ready = 0; o_bad_en = 0; o_lat = 0;
    o_unstable = 0; o_hold_ready = 0; o_data = 16'h0000; o_nzcv = 4'h0;
    @(negedge clk);
    while (!req_ready && (o_wait < 20)) begin
      o_wait++;
      @(negedge clk);
    end
    if (!req_ready) begin
      o_timeout = 1'b1;
    end else begin
      req_op = op; req_w16 = w16; req_a = a; req_b = b; req_c = c; req_v = v;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
      k = 0;
      @(negedge clk);
      while (!res_valid && (k < 10)) begin
        k++;
        if (req_ready) o_busy_ready++;
        if (en_count() != exp_en) o_bad_en++;
        @(negedge clk);
      end
      o_lat = k;
      if (!res_valid) begin
        o_timeout = 1'b1;
      end else begin
        o_data = res_data;
        o_nzcv = {res_n, res_z, res_c, res_v};
        if (en_count() != 0) o_bad_en++;
        if (req_ready) o_busy_ready++;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if ((res_valid !== 1'b1) || (res_data !== o_data) || ({res_n, res_z, res_c, res_v} !== o_nzcv)) o_unstable++;
          if (req_ready) o_hold_ready++;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_op = 3'd0; req_w16 = 1'b0; req_a = 16'h0000; req_b = 16'h0000; req_c = 1'b0; req_v = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_checks++;
    if ({res_data, res_n, res_z, res_c, res_v} !== 20'h00000) begin
      n_fail++; $display("FAIL reset_result: got %h/%b%b%b%b expected 0", res_data, res_n, res_z, res_c, res_v);
    end
    n_checks++;
    if ((en_count() !== 0) || ({alu_a, alu_b, alu_cin} !== 17'h00000)) begin
      n_fail++; $display("FAIL reset_alu_outputs: got en=%0d a=%h b=%h cin=%b expected all 0", en_count(), alu_a, alu_b, alu_cin);
    end
    rst_n = 1'b1;
    begin
      int w;
      w = 0;
      while (!req_ready && (w < 5)) begin w++; @(negedge clk); end
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    end
  endtask

  task automatic test_directed();
    vec_t vecs[8];
    vecs[0] = '{3'd0, 1'b0, 16'h0050, 16'h0050, 1'b0, 1'b0, 16'h00A0, 4'b1001, 2'd1};
    vecs[1] = '{3'd0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 4'b0000, 2'd2};
    vecs[2] = '{3'd5, 1'b1, 16'h0101, 16'h0000, 1'b0, 1'b0, 16'h0080, 4'b0010, 2'd2};
    vecs[3] = '{3'd6, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h8000, 4'b1010, 2'd2};
    vecs[4] = '{3'd7, 1'b0, 16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 4'b0111, 2'd1};
    vecs[5] = '{3'd2, 1'b0, 16'h00F0, 16'h000F, 1'b1, 1'b0, 16'h0000, 4'b0110, 2'd1};
    vecs[6] = '{3'd1, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h00FF, 4'b1000, 2'd1};
    vecs[7] = '{3'd4, 1'b1, 16'h1200, 16'h0034, 1'b0, 1'b1, 16'h1234, 4'b0001, 2'd2};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].w16, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].v, 0);
      n_checks++;
      if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL directed_timeout[%0d]: got timeout expected completion", i); end
      n_checks++;
      if (o_data !== vecs[i].exp_data) begin n_fail++; $display("FAIL directed_data[%0d]: got %h expected %h", i, o_data, vecs[i].exp_data); end
      n_checks++;
      if (o_nzcv !== vecs[i].exp_nzcv) begin n_fail++; $display("FAIL directed_nzcv[%0d]: got %b expected %b", i, o_nzcv, vecs[i].exp_nzcv); end
      n_checks++;
      if (o_lat !== int'(vecs[i].exp_lat)) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, o_lat, vecs[i].exp_lat); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        w16, c, v;
    logic [15:0] a, b, er;
    logic [3:0]  en;
    for (int i = 0; i < 80; i++) begin
      op  = 3'($urandom_range(0, 7));
      w16 = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
      c   = 1'($urandom_range(0, 1));
      v   = 1'($urandom_range(0, 1));
      ref_model(op, w16, a, b, c, v, er, en);
      run_op(op, w16, a, b, c, v, 0);
      n_checks++;
      if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL random_timeout[%0d]: op=%0d got timeout expected completion", i, op); end
      n_checks++;
      if (o_data !== er) begin n_fail++; $display("FAIL random_data[%0d]: op=%0d w16=%b a=%h b=%h c=%b got %h expected %h", i, op, w16, a, b, c, o_data, er); end
      n_checks++;
      if (o_nzcv !== en) begin n_fail++; $display("FAIL random_nzcv[%0d]: op=%0d w16=%b a=%h b=%h c=%b v=%b got %b expected %b", i, op, w16, a, b, c, v, o_nzcv, en); end
      n_checks++;
      if (o_lat !== (w16 ? 2 : 1)) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, o_lat, (w16 ? 2 : 1)); end
      n_checks++;
      if (o_busy_ready !== 0) begin n_fail++; $display("FAIL random_busy_ready[%0d]: got %0d ready cycles expected 0", i, o_busy_ready); end
      n_checks++;
      if (o_bad_en !== 0) begin n_fail++; $display("FAIL random_enables[%0d]: got %0d bad cycles expected 0", i, o_bad_en); end
    end
  endtask

  task automatic test_backpressure();
    run_op(3'd0, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 5);
    n_checks++;
    if (o_data !== 16'h5556) begin n_fail++; $display("FAIL backpressure_data: got %h expected 5556", o_data); end
    n_checks++;
    if (o_unstable !== 0) begin n_fail++; $display("FAIL backpressure_stable: got %0d changed cycles expected 0", o_unstable); end
    n_checks++;
    if (o_hold_ready !== 0) begin n_fail++; $display("FAIL backpressure_ready: got %0d ready cycles expected 0", o_hold_ready); end
  endtask

  task automatic test_back_to_back();
    run_op(3'd3, 1'b0, 16'h00AA, 16'h00FF, 1'b0, 1'b0, 0);
    run_op(3'd3, 1'b1, 16'hAAAA, 16'h0F0F, 1'b0, 1'b0, 0);
    n_checks++;
    if (o_wait !== 0) begin n_fail++; $display("FAIL back_to_back_wait: got %0d idle waits expected 0", o_wait); end
    n_checks++;
    if (o_data !== 16'hA5A5) begin n_fail++; $display("FAIL back_to_back_data: got %h expected a5a5", o_data); end
  endtask

  task automatic test_midop_reset();
    int w, seen_valid;
    w = 0;
    @(negedge clk);
    while (!req_ready && (w < 20)) begin w++; @(negedge clk); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready_timeout: got %b expected 1", req_ready); end
    req_op = 3'd0; req_w16 = 1'b1; req_a = 16'h00FF; req_b = 16'h0001; req_c = 1'b0; req_v = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midop_res_valid: got %b expected 0", res_valid); end
    n_checks++;
    if (en_count() !== 0) begin n_fail++; $display("FAIL midop_enables: got %0d expected 0", en_count()); end
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL midop_req_ready: got %b expected 0", req_ready); end
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid) seen_valid++;
    end
    n_checks++;
    if (seen_valid !== 0) begin n_fail++; $display("FAIL midop_no_result: got %0d valid cycles expected 0", seen_valid); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_idle_after: got %b expected 1", req_ready); end
  endtask

`ifdef ALU_SEQ_BCD_EN
  task automatic test_bcd();
    req_d = 1'b1;
    run_op(3'd0, 1'b0, 16'h0019, 16'h0028, 1'b0, 1'b0, 0);
    req_d = 1'b0;
    n_checks++;
    if (o_data !== 16'h0047) begin n_fail++; $display("FAIL bcd_data: got %h expected 0047", o_data); end
    n_checks++;
    if (o_nzcv[1] !== 1'b0) begin n_fail++; $display("FAIL bcd_carry: got %b expected 0", o_nzcv[1]); end
  endtask
`endif

  initial begin
`ifdef ALU_SEQ_BCD_EN
    req_d = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_midop_reset();
`ifdef ALU_SEQ_BCD_EN
    test_bcd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
